// File: rtl/uart_pkg.sv
// Shared UART constants and types: FSM state encoding, parity modes,
// default oversampling ratio and a 2-of-3 majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int OVERSAMPLE_DEF = 16;

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[1] & h[2]) | (h[0] & h[2]);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous pins; resets to the line-idle level 1.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: synchronizer flops reset to 1 (idle line) so leaving reset never
  // presents a false falling edge to the receiver.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8N1 / 8-bit+parity frame recovery.
// Optional macro UART_RX_MAJORITY_VOTE_EN: sample points use a 2-of-3 vote.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_tick,
  input  logic                 rx,
  input  logic [1:0]           parity,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_CNT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  logic                 rx_s;
  logic                 samp;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           par_cfg;
  logic                 par_err_r;
  logic                 wait_high;
  logic                 par_on;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote over the three preceding ticks so a one-tick glitch exactly at the
  // sample point cannot flip the recovered bit.
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '1;
    end else if (b_tick) begin
      hist <= {hist[1:0], rx_s};
    end
  end

  assign samp = maj3(hist);
`else
  assign samp = rx_s;
`endif

  assign par_on  = (par_cfg == PAR_ODD) || (par_cfg == PAR_EVEN);
  assign rx_busy = (state != S_IDLE);

  // NOTE: all state here is sequential, so every assignment below is
  // non-blocking; rx_done defaults low each cycle to make it a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_cfg    <= PAR_NONE;
      par_err_r  <= 1'b0;
      wait_high  <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (b_tick) begin
        case (state)
          S_IDLE: begin
            // After a low stop bit the line must return high before re-arming.
            if (wait_high) begin
              if (rx_s) wait_high <= 1'b0;
            end else if (!rx_s) begin
              state     <= S_START;
              tick_cnt  <= '0;
              par_cfg   <= parity;
              par_err_r <= 1'b0;
            end
          end
          S_START: begin
            if (tick_cnt == HALF_CNT) begin
              if (!samp) begin
                state    <= S_DATA;
                tick_cnt <= '0;
                bit_idx  <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt == FULL_CNT) begin
              tick_cnt  <= '0;
              shift_reg <= {samp, shift_reg[DATA_BITS-1:1]};
              bit_idx   <= bit_idx + 1'b1;
              if (bit_idx == LAST_BIT) state <= par_on ? S_PARITY : S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (tick_cnt == FULL_CNT) begin
              tick_cnt  <= '0;
              par_err_r <= (par_cfg == PAR_ODD) ? ~(^shift_reg ^ samp)
                                                :  (^shift_reg ^ samp);
              state     <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (tick_cnt == FULL_CNT) begin
              // Leave at mid stop bit so a back-to-back start edge is caught.
              tick_cnt   <= '0;
              state      <= S_IDLE;
              rx_data    <= shift_reg;
              frame_err  <= ~samp;
              parity_err <= par_err_r;
              rx_done    <= 1'b1;
              wait_high  <= ~samp;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a slot-level line model drives rx, expected
// frames are queued at send time and a monitor checks every rx_done strobe.
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] parity = 2'b00;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .b_tick     (b_tick),
    .rx         (rx),
    .parity     (parity),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: strobe with rx_data 0x%0h, none expected at %0t", rx_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.data);
        check("parity_err", parity_err, e.perr);
        check("frame_err", frame_err, e.ferr);
        check("busy_at_done", rx_busy, 1'b0);
      end
    end
  end

  // One oversample slot: the level set here is what the receiver sees on this slot's b_tick.
  task automatic drive_slot(input logic v);
    @(negedge clk) rx = v;
    @(negedge clk);
    @(negedge clk) b_tick = 1'b1;
    @(negedge clk) b_tick = 1'b0;
  endtask

  task automatic idle_slots(input int n);
    for (int i = 0; i < n; i++) drive_slot(1'b1);
  endtask

  task automatic drive_bit(input logic v, input int flip_slot);
    for (int j = 0; j < 16; j++) drive_slot((j == flip_slot) ? ~v : v);
  endtask

  // Sends one full frame and queues the result the specification predicts.
  // glitch_bit >= 0 inverts that data bit for the single centre slot (slot 8).
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pmode,
                            input bit bad_par, input logic stop_v, input int glitch_bit);
    exp_t e;
    bit   par_en;
    logic pbit;
    par_en = (pmode == 2'b01) || (pmode == 2'b10);
    // Correct bit makes the total count of ones odd (odd mode) or even (even mode).
    pbit = (pmode == 2'b01) ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1);
    if (bad_par) pbit = ~pbit;
    e.data = d;
`ifndef UART_RX_MAJORITY_VOTE_EN
    if (glitch_bit >= 0) e.data = d ^ (8'h01 << glitch_bit);
`endif
    e.perr = par_en && bad_par;
    e.ferr = ~stop_v;
    exp_q.push_back(e);
    parity = pmode;
    drive_bit(1'b0, -1);
    parity = 2'($urandom);  // must be ignored mid-frame
    for (int k = 0; k < 8; k++) drive_bit(d[k], (k == glitch_bit) ? 8 : -1);
    if (par_en) drive_bit(pbit, -1);
    drive_bit(stop_v, -1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    b_tick = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    do_reset();
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    idle_slots(4);

    // Plain 8N1
    base = done_cnt;
    send_frame(8'hA5, 2'b00, 0, 1'b1, -1);
    idle_slots(4);
    wait_drain("a5");
    check("a5_strobes", done_cnt - base, 1);
    check("a5_busy_after", rx_busy, 1'b0);

    // Even parity, good then bad
    send_frame(8'h3C, 2'b10, 0, 1'b1, -1);
    idle_slots(3);
    send_frame(8'h3C, 2'b10, 1, 1'b1, -1);
    idle_slots(3);
    wait_drain("3c");

    // Start-bit glitch: 4 low slots, then idle
    base = done_cnt;
    for (int i = 0; i < 4; i++) drive_slot(1'b0);
    idle_slots(24);
    check("glitch_strobes", done_cnt - base, 0);
    check("glitch_busy", rx_busy, 1'b0);
    send_frame(8'h5A, 2'b00, 0, 1'b1, -1);
    idle_slots(3);
    wait_drain("5a");

    // Frame error then clean frame
    send_frame(8'h55, 2'b00, 0, 1'b0, -1);
    idle_slots(4);
    send_frame(8'h01, 2'b00, 0, 1'b1, -1);
    idle_slots(3);
    wait_drain("ferr");

    // Back-to-back frames
    base = done_cnt;
    send_frame(8'h01, 2'b00, 0, 1'b1, -1);
    send_frame(8'hFE, 2'b00, 0, 1'b1, -1);
    idle_slots(3);
    wait_drain("b2b");
    check("b2b_strobes", done_cnt - base, 2);

    // Reset during bit 3 of 0xFF
    base = done_cnt;
    parity = 2'b00;
    drive_bit(1'b0, -1);
    for (int k = 0; k < 3; k++) drive_bit(1'b1, -1);
    for (int j = 0; j < 8; j++) drive_slot(1'b1);
    check("pre_reset_busy", rx_busy, 1'b1);
    do_reset();
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_parity_err", parity_err, 1'b0);
    check("midrst_rx_busy", rx_busy, 1'b0);
    check("midrst_strobes", done_cnt - base, 0);
    idle_slots(4);
    send_frame(8'h81, 2'b00, 0, 1'b1, -1);
    idle_slots(3);
    wait_drain("81");

    // Single-slot glitch at the bit-2 centre
    send_frame(8'h00, 2'b00, 0, 1'b1, 2);
    idle_slots(3);
    wait_drain("glitch_bit2");

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic [1:0] pm;
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      send_frame(d, pm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), -1);
      idle_slots($urandom_range(2, 10));
    end
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
